mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage (I port) and the memory stage (D port). It grants one transaction at a time with data priority and a bounded-starvation rule for fetch. It drives the memory request/ack handshake and returns read data plus per-port done/stall strobes that feed the pipeline `halt` inputs. It sits between the fetch and memory pipeline stages and the memory port, and honours the writeback flush (exception/rfe) for fetch traffic.

## Interface
- `STARVE_MAX`, default 4: maximum consecutive D grants while I is waiting. Legal range 1..15.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: writeback exception/rfe; squashes in-flight and same-cycle fetch.
- `i_req` input 1: fetch read request, level, held until `i_done`.
- `i_addr` input 32: fetch address.
- `i_rdata` output 32: fetch read data, valid with `i_done`.
- `i_done` output 1: one-cycle fetch completion strobe.
- `i_stall` output 1: `i_req & ~i_done` (combinational).
- `d_req` input 1: data request, level, held until `d_done`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_be` input 4: byte enables.
- `d_addr` input 32: data address.
- `d_wdata` input 32: store data.
- `d_rdata` output 32: load data, valid with `d_done`.
- `d_done` output 1: one-cycle data completion strobe.
- `d_stall` output 1: `d_req & ~d_done` (combinational).
- `m_req` output 1: memory request, registered.
- `m_we` output 1: memory write enable.
- `m_be` output 4: memory byte enables.
- `m_addr` output 32: memory address.
- `m_wdata` output 32: memory write data.
- `m_ack` input 1: memory completion, one cycle, variable latency ≥1.
- `m_rdata` input 32: memory read data, valid with `m_ack`.

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch transaction in flight.
  - BUSY_D: data transaction in flight.
- Grant in IDLE, evaluated each cycle:
  - Grant D when `d_req & ~(i_req & ~flush & streak==STARVE_MAX)`.
  - Otherwise grant I when `i_req & ~flush`.
  - Otherwise stay in IDLE.
- On grant, register `m_addr/m_we/m_be/m_wdata` and set `m_req=1`.
  - I grants force `m_we=0` and `m_be=4'hF`.
  - All `m_*` outputs stay stable until the ack cycle.
- On `m_ack` in BUSY_x:
  - Clear `m_req`, latch `m_rdata` into `x_rdata`, pulse `x_done` next cycle, go to IDLE.
  - The IDLE cycle after ack may grant immediately. The requester drops its request in the cycle `done` is seen.
- `m_ack` in IDLE is ignored.
- `streak`: 4-bit counter.
  - On a D grant, `streak` increments (saturating at `STARVE_MAX`) if `i_req & ~flush` is true that cycle; otherwise it clears.
  - On an I grant, `streak` clears.
- Flush:
  - `flush` in BUSY_I sets `drop`. The memory transaction still completes on `m_ack` but `i_done` is suppressed; `i_rdata` is not updated.
  - `drop` clears on ack.
  - `flush` has no effect on D traffic. The memory stage gates `d_req` itself.
- `i_stall`/`d_stall` are pure combinational functions of `req` and `done`. They are not registered.

## Timing
- Reset (async assert, sync-safe deassert):
  - State = IDLE; `m_req=0`, `m_we=0`, `m_be=0`, `m_addr=0`, `m_wdata=0`.
  - `i_done=0`, `d_done=0`, `i_rdata=0`, `d_rdata=0`; `streak=0`, `drop=0`.
- Reset mid-transaction abandons it; no done is issued. The memory side is reset by the same `rst_n`.
- Latency, with request sampled at edge 0 in IDLE:
  - `m_req` is high after edge 0.
  - With ack at edge k≥1, `done` is high after edge k for exactly one cycle.
  - Minimum request-to-done: 2 cycles.
- Back-to-back: throughput is one transaction per (ack latency + 1) cycles. One IDLE cycle follows every ack.
- Simultaneous `flush` and `m_ack` in BUSY_I: the ack completes and `i_done` is suppressed.
- Simultaneous `flush` and `i_req` in IDLE with no `d_req`: no grant.

## Test plan
- Single load: `d_req=1`, `d_we=0`, `d_addr=0x100`, memory acks 3 cycles after `m_req` with `m_rdata=0xDEADBEEF` -> `m_addr=0x100`, `m_we=0`, `d_done` pulses once with `d_rdata=0xDEADBEEF`, `d_stall` high until the done cycle.
- Contention: `i_req` and `d_req` both held, ack latency 1, `STARVE_MAX=4` -> grant order D,D,D,D,I,D,D,D,D,I…; `i_done` appears after the 4th `d_done`.
- Store: `d_we=1`, `d_be=4'b0011`, `d_wdata=0x12345678`, `d_addr=0x204` -> `m_we=1`, `m_be=0011`, `m_wdata=0x12345678`, all stable until ack; `d_done` pulses once.
- Flush: fetch in BUSY_I, `flush` pulsed 1 cycle before ack -> no `i_done`, `i_rdata` unchanged, state returns to IDLE, next `i_req` is granted normally.
- Reset mid-operation: `rst_n` low while `m_req=1` -> `m_req`, `i_done` and `d_done` drop immediately (async); after release, a new `d_req` is granted with `streak=0`.
- Spurious ack: `m_ack=1` while IDLE -> no done strobe, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between fetch (I) and data (D) with data priority and bounded fetch starvation
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : squashes in-flight and same-cycle fetch traffic
//   i_req/i_addr        : fetch read request; i_rdata/i_done/i_stall back to fetch
//   d_req/d_we/d_be/d_addr/d_wdata : data request; d_rdata/d_done/d_stall back to memory stage
//   m_req/m_we/m_be/m_addr/m_wdata : registered memory request; m_ack/m_rdata memory completion
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
  state_e      state_q, state_d;
  logic        m_req_q, m_req_d, m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d, streak_q, streak_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d, d_done_q, d_done_d, drop_q, drop_d;
  logic        i_ok, gnt_d, gnt_i, starved;
  assign i_ok    = i_req & ~flush;
  assign starved = i_ok & (streak_q == 4'(STARVE_MAX));
  assign gnt_d   = (state_q == IDLE) & d_req & ~starved;
  assign gnt_i   = (state_q == IDLE) & ~gnt_d & i_ok;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      streak_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      streak_q  <= streak_d;
      drop_q    <= drop_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    streak_d  = streak_q;
    drop_d    = drop_q;
    if (gnt_d) begin
      state_d   = BUSY_D;
      m_req_d   = 1'b1;
      m_we_d    = d_we;
      m_be_d    = d_be;
      m_addr_d  = d_addr;
      m_wdata_d = d_wdata;
      // count D wins only while fetch is actually waiting
      streak_d  = i_ok ? (streak_q == 4'(STARVE_MAX) ? streak_q : streak_q + 4'd1) : '0;
    end else if (gnt_i) begin
      state_d   = BUSY_I;
      m_req_d   = 1'b1;
      m_we_d    = 1'b0;
      m_be_d    = 4'hF;
      m_addr_d  = i_addr;
      m_wdata_d = '0;
      streak_d  = '0;
    end else if (state_q != IDLE && m_ack) begin
      state_d = IDLE;
      m_req_d = 1'b0;
      drop_d  = 1'b0;
      if (state_q == BUSY_D) begin
        d_rdata_d = m_rdata;
        d_done_d  = 1'b1;
      end else if (!(drop_q || flush)) begin
        i_rdata_d = m_rdata;
        i_done_d  = 1'b1;
      end
    end else if (state_q == BUSY_I && flush) begin
      // the memory access still has to finish; only its result is discarded
      drop_d = 1'b1;
    end
  end
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_stall = i_req & ~i_done_q;
  assign d_stall = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven and scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, i_stall, d_done, d_stall, m_req, m_we;
  logic [3:0]  m_be;
  int total = 0, bad = 0;
  typedef struct {logic is_d; logic [31:0] rdata;} exp_t;
  typedef struct {
    logic is_d; logic we; logic [3:0] be; logic [31:0] addr, wdata, rdata; int lat;
    logic exp_we; logic [3:0] exp_be; logic [31:0] exp_wdata;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[5];
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // advance one cycle and retire any completion against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (i_done || d_done) begin
      if (sb.size() == 0) check("unexpected_done", {30'd0, i_done, d_done}, 32'd0);
      else begin
        e = sb.pop_front();
        check("done_port", {30'd0, i_done, d_done}, e.is_d ? 32'd1 : 32'd2);
        check("done_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
      end
    end
  endtask
  task automatic wait_grant(input logic [31:0] addr);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_req && n < 8);
    check("grant_latency", n, 1);
    check("grant_addr", m_addr, addr);
  endtask
  task automatic ack(input int lat, input logic [31:0] rdata);
    logic [31:0] a, w;
    logic [5:0]  c;
    a = m_addr;
    w = m_wdata;
    c = {m_req, m_we, m_be};
    for (int j = 1; j < lat; j++) begin
      tick();
      check("hold_addr", m_addr, a);
      check("hold_wdata", m_wdata, w);
      check("hold_ctl", {26'd0, m_req, m_we, m_be}, {26'd0, c});
    end
    m_rdata = rdata;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
  endtask
  // both requesters held: with STARVE_MAX=4 every fifth grant goes to fetch
  task automatic run_grants(input int n);
    logic is_d;
    for (int g = 0; g < n; g++) begin
      is_d = (g % 5) != 4;
      wait_grant(is_d ? 32'h2000 : 32'h1000);
      sb.push_back('{is_d, 32'hA0 + 32'(g)});
      ack(1, 32'hA0 + 32'(g));
      check("contend_done", {30'd0, i_done, d_done}, is_d ? 32'd1 : 32'd2);
    end
  endtask
  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 4'hF,    32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 4'hF,    32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h204, 32'h12345678, 32'h0,        2, 1'b1, 4'b0011, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 4'h5,    32'h40,  32'h0,        32'hCAFEF00D, 1, 1'b0, 4'hF,    32'h0};
    vecs[3] = '{1'b1, 1'b0, 4'b1000, 32'h3FC, 32'hFFFF0000, 32'h000000A5, 5, 1'b0, 4'b1000, 32'hFFFF0000};
    vecs[4] = '{1'b0, 1'b0, 4'h0,    32'h44,  32'h0,        32'h13579BDF, 2, 1'b0, 4'hF,    32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {26'd0, m_req, m_we, m_be}, 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_done", {30'd0, i_done, d_done}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      d_we = v.we;
      d_be = v.be;
      d_wdata = v.wdata;
      if (v.is_d) begin
        d_req = 1'b1;
        d_addr = v.addr;
      end else begin
        i_req = 1'b1;
        i_addr = v.addr;
      end
      sb.push_back('{v.is_d, v.rdata});
      #1;
      check("stall_req", {31'd0, v.is_d ? d_stall : i_stall}, 32'd1);
      wait_grant(v.addr);
      check("m_we", {31'd0, m_we}, {31'd0, v.exp_we});
      check("m_be", {28'd0, m_be}, {28'd0, v.exp_be});
      if (v.is_d) check("m_wdata", m_wdata, v.exp_wdata);
      ack(v.lat, v.rdata);
      check("done_now", {31'd0, v.is_d ? d_done : i_done}, 32'd1);
      check("stall_done", {31'd0, v.is_d ? d_stall : i_stall}, 32'd0);
      d_req = 1'b0;
      i_req = 1'b0;
      tick();
      check("done_pulse", {30'd0, i_done, d_done}, 32'd0);
      check("idle_mreq", {31'd0, m_req}, 32'd0);
    end
    m_ack = 1'b1;
    m_rdata = 32'h0BADF00D;
    tick();
    m_ack = 1'b0;
    check("spur_done", {30'd0, i_done, d_done}, 32'd0);
    check("spur_mreq", {31'd0, m_req}, 32'd0);
    tick();
    check("spur_done2", {30'd0, i_done, d_done}, 32'd0);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h500;
    sb.push_back('{1'b1, 32'h5A5A5A5A});
    wait_grant(32'h500);
    ack(2, 32'h5A5A5A5A);
    d_req = 1'b0;
    tick();
    i_addr = 32'h1000;
    d_addr = 32'h2000;
    d_be = 4'hF;
    i_req = 1'b1;
    d_req = 1'b1;
    run_grants(10);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    check("contend_idle", {31'd0, m_req}, 32'd0);
    i_req = 1'b1;
    i_addr = 32'h300;
    wait_grant(32'h300);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_rdata = 32'hBAD0BAD0;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    check("flush_no_done", {31'd0, i_done}, 32'd0);
    check("flush_rdata_kept", i_rdata, 32'hA9);
    check("flush_mreq_clr", {31'd0, m_req}, 32'd0);
    i_addr = 32'h304;
    wait_grant(32'h304);
    sb.push_back('{1'b0, 32'h55AA55AA});
    ack(1, 32'h55AA55AA);
    check("refetch_done", {31'd0, i_done}, 32'd1);
    i_addr = 32'h308;
    wait_grant(32'h308);
    flush = 1'b1;
    m_rdata = 32'h11111111;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    check("flush_ack_no_done", {31'd0, i_done}, 32'd0);
    check("flush_ack_rdata", i_rdata, 32'h55AA55AA);
    tick();
    check("flush_idle_no_grant", {31'd0, m_req}, 32'd0);
    flush = 1'b0;
    wait_grant(32'h308);
    sb.push_back('{1'b0, 32'h77});
    ack(1, 32'h77);
    check("after_flush_done", {31'd0, i_done}, 32'd1);
    i_req = 1'b0;
    tick();
    d_req = 1'b1;
    d_addr = 32'h700;
    wait_grant(32'h700);
    sb.push_back('{1'b1, 32'h70});
    ack(1, 32'h70);
    check("pre_rst_done", {31'd0, d_done}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_done", {31'd0, d_done}, 32'd0);
    check("rst_clears_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_addr = 32'h1000;
    d_addr = 32'h2000;
    i_req = 1'b1;
    d_req = 1'b1;
    run_grants(3);
    wait_grant(32'h2000);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mreq", {31'd0, m_req}, 32'd0);
    check("rst_mid_done", {30'd0, i_done, d_done}, 32'd0);
    check("rst_mid_addr", m_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    run_grants(5);
    check("post_rst_i_rdata", i_rdata, 32'hA4);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
